if_fetch_queue: RTL

- Parametrised successor to the single-entry IF stage register; sits between IF_stage and the ID stage.
- Buffers up to DEPTH fetched {PC, Instruction} pairs so fetch can run ahead of decode.
- Honours freeze (ID stall) and flush (taken branch) exactly as the stage register does.
- Adds a valid/ready handshake on the fetch side, plus occupancy and status outputs.

---
 rtl/if_fetch_queue.sv | 76 +++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Fetch queue between IF and ID: a DEPTH-entry first-word-fall-through FIFO of
// {PC, instruction} pairs with ID freeze, branch flush and a ready/valid push side.
module if_fetch_queue #(
  parameter  int PC_W    = 32,
  parameter  int INSTR_W = 32,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic               push_ready,
  input  logic               freeze,
  input  logic               flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pop;
  logic               push;

  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_W'(DEPTH));
  assign count      = cnt;
  assign out_valid  = !empty;
  assign pop        = out_valid & !freeze & !flush;
  // A full queue can still accept a pair when the head leaves in the same cycle.
  assign push_ready = !flush & (!full | pop);
  assign push       = push_valid & push_ready;

  // Empty queue presents an all-zero bubble to ID.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

endmodule
